// File: rtl/rs_preio_soc_link.sv
// Serial SoC<->fabric pad link: one TX and one RX UART-style engine sharing only clk and reset.
// Define RS_PREIO_LINK_PARITY_EN to add an even-parity bit after the data bits of every frame.
module rs_preio_soc_link #(
    parameter int DATA_WIDTH = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  gfpga_pad_RS_PREIO_A2F,
    input  logic                  gfpga_pad_RS_PREIO_F2A,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_frame_err,
    output logic                  rx_parity_err
);
    localparam int CW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA,
`ifdef RS_PREIO_LINK_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA,
`ifdef RS_PREIO_LINK_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP, RX_WAIT_IDLE
    } rx_state_t;

    tx_state_t             r_tx_state, w_tx_state_next;
    logic [CW-1:0]         r_tx_cnt;
    logic [IW-1:0]         r_tx_idx;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic                  r_tx_en;
    logic                  w_tx_accept, w_tx_bit_end;
`ifdef RS_PREIO_LINK_PARITY_EN
    logic                  r_tx_par;
`endif

    assign w_tx_bit_end = (r_tx_cnt == BIT_LAST);
    assign w_tx_accept  = tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) r_tx_state <= TX_IDLE;
        else          r_tx_state <= w_tx_state_next;
    end

    always_comb begin
        w_tx_state_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE:  if (w_tx_accept) w_tx_state_next = TX_START;
            TX_START: if (w_tx_bit_end) w_tx_state_next = TX_DATA;
            TX_DATA:  if (w_tx_bit_end && r_tx_idx == IDX_LAST)
`ifdef RS_PREIO_LINK_PARITY_EN
                          w_tx_state_next = TX_PARITY;
            TX_PARITY: if (w_tx_bit_end) w_tx_state_next = TX_STOP;
`else
                          w_tx_state_next = TX_STOP;
`endif
            TX_STOP:  if (w_tx_bit_end) w_tx_state_next = TX_IDLE;
            default:  w_tx_state_next = TX_IDLE;
        endcase
    end

    // r_tx_en keeps tx_ready low while reset is held, even though the state is already IDLE.
    always_comb begin
        tx_ready               = 1'b0;
        gfpga_pad_RS_PREIO_A2F = 1'b1;
        case (r_tx_state)
            TX_IDLE:   tx_ready = r_tx_en;
            TX_START:  gfpga_pad_RS_PREIO_A2F = 1'b0;
            TX_DATA:   gfpga_pad_RS_PREIO_A2F = r_tx_shift[0];
`ifdef RS_PREIO_LINK_PARITY_EN
            TX_PARITY: gfpga_pad_RS_PREIO_A2F = r_tx_par;
`endif
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tx_en    <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
`ifdef RS_PREIO_LINK_PARITY_EN
            r_tx_par   <= 1'b0;
`endif
        end else begin
            r_tx_en <= 1'b1;
            if (r_tx_state == TX_IDLE) begin
                r_tx_cnt <= '0;
                r_tx_idx <= '0;
                if (w_tx_accept) begin
                    r_tx_shift <= tx_data;
`ifdef RS_PREIO_LINK_PARITY_EN
                    r_tx_par   <= ^tx_data;
`endif
                end
            end else begin
                r_tx_cnt <= w_tx_bit_end ? '0 : r_tx_cnt + 1'b1;
                if (r_tx_state == TX_DATA && w_tx_bit_end) begin
                    r_tx_shift <= r_tx_shift >> 1;
                    r_tx_idx   <= r_tx_idx + 1'b1;
                end
            end
        end
    end

    rx_state_t             r_rx_state, w_rx_state_next;
    logic [CW-1:0]         r_rx_cnt;
    logic [IW-1:0]         r_rx_idx;
    logic [DATA_WIDTH-1:0] r_rx_shift, r_rx_data;
    logic                  r_rx_valid, r_rx_ferr;
    logic                  w_rx_in, w_rx_bit_end, w_rx_half;
    logic                  w_rx_shift_en, w_rx_deliver, w_rx_bad_stop;
    logic [DATA_WIDTH:0]   w_rx_cat;
`ifdef RS_PREIO_LINK_PARITY_EN
    logic                  r_rx_par_bad, r_rx_perr, w_rx_par_chk;
`endif

    assign w_rx_in      = gfpga_pad_RS_PREIO_F2A;
    assign w_rx_bit_end = (r_rx_cnt == BIT_LAST);
    assign w_rx_half    = (r_rx_cnt == HALF_LAST);
    assign w_rx_cat     = {w_rx_in, r_rx_shift};

    always_ff @(posedge clk) begin
        if (!reset_n) r_rx_state <= RX_IDLE;
        else          r_rx_state <= w_rx_state_next;
    end

    always_comb begin
        w_rx_state_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:      if (!w_rx_in) w_rx_state_next = RX_START;
            RX_START:     if (w_rx_half) w_rx_state_next = w_rx_in ? RX_IDLE : RX_DATA;
            RX_DATA:      if (w_rx_bit_end && r_rx_idx == IDX_LAST)
`ifdef RS_PREIO_LINK_PARITY_EN
                              w_rx_state_next = RX_PARITY;
            RX_PARITY:    if (w_rx_bit_end) w_rx_state_next = RX_STOP;
`else
                              w_rx_state_next = RX_STOP;
`endif
            RX_STOP:      if (w_rx_bit_end) w_rx_state_next = w_rx_in ? RX_IDLE : RX_WAIT_IDLE;
            RX_WAIT_IDLE: if (w_rx_in) w_rx_state_next = RX_IDLE;
            default:      w_rx_state_next = RX_IDLE;
        endcase
    end

    always_comb begin
        w_rx_shift_en = 1'b0;
        w_rx_deliver  = 1'b0;
        w_rx_bad_stop = 1'b0;
`ifdef RS_PREIO_LINK_PARITY_EN
        w_rx_par_chk  = 1'b0;
`endif
        case (r_rx_state)
            RX_DATA:   w_rx_shift_en = w_rx_bit_end;
`ifdef RS_PREIO_LINK_PARITY_EN
            RX_PARITY: w_rx_par_chk = w_rx_bit_end;
`endif
            RX_STOP: begin
                w_rx_deliver  = w_rx_bit_end && w_rx_in;
                w_rx_bad_stop = w_rx_bit_end && !w_rx_in;
            end
            default: ;
        endcase
    end

    // The START counter runs to mid-bit; every later sample is one full bit period on.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rx_cnt     <= '0;
            r_rx_idx     <= '0;
            r_rx_shift   <= '0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_ferr    <= 1'b0;
`ifdef RS_PREIO_LINK_PARITY_EN
            r_rx_par_bad <= 1'b0;
            r_rx_perr    <= 1'b0;
`endif
        end else begin
            r_rx_valid <= w_rx_deliver;
            r_rx_ferr  <= w_rx_bad_stop;
            case (r_rx_state)
                RX_IDLE, RX_WAIT_IDLE: r_rx_cnt <= '0;
                RX_START: r_rx_cnt <= w_rx_half ? '0 : r_rx_cnt + 1'b1;
                default:  r_rx_cnt <= w_rx_bit_end ? '0 : r_rx_cnt + 1'b1;
            endcase
            if (r_rx_state == RX_START) r_rx_idx <= '0;
            else if (w_rx_shift_en)     r_rx_idx <= r_rx_idx + 1'b1;
            if (w_rx_shift_en) r_rx_shift <= w_rx_cat[DATA_WIDTH:1];
            if (w_rx_deliver)  r_rx_data  <= r_rx_shift;
`ifdef RS_PREIO_LINK_PARITY_EN
            if (w_rx_par_chk) r_rx_par_bad <= w_rx_in ^ (^r_rx_shift);
            r_rx_perr <= w_rx_deliver && r_rx_par_bad;
`endif
        end
    end

    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign rx_frame_err = r_rx_ferr;
`ifdef RS_PREIO_LINK_PARITY_EN
    assign rx_parity_err = r_rx_perr;
`else
    assign rx_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_rs_preio_soc_link.sv
// Scoreboard bench for rs_preio_soc_link: random and directed frames on both pads,
// with expected line bits and received words derived from the frame format.
`timescale 1ns/1ps
module tb_rs_preio_soc_link;
    localparam int DW = 8;
    localparam int BC = 4;
`ifdef RS_PREIO_LINK_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NBITS = 2 + DW + PB;
    localparam int FRAME = NBITS * BC;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          a2f;
    logic          f2a;
    logic          f2a_drv = 1'b1;
    logic          loopback = 1'b0;
    logic [DW-1:0] rx_data;
    logic          rx_valid, rx_frame_err, rx_parity_err;

    always #5 clk = ~clk;
    assign f2a = loopback ? a2f : f2a_drv;

    rs_preio_soc_link #(.DATA_WIDTH(DW), .BIT_CYCLES(BC)) dut (
        .clk(clk), .reset_n(reset_n),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .gfpga_pad_RS_PREIO_A2F(a2f), .gfpga_pad_RS_PREIO_F2A(f2a),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err)
    );

    typedef struct { logic [DW-1:0] data; logic perr; } rx_exp_t;

    int            checks = 0;
    int            failures = 0;
    int            cycle = 0;
    int            ferr_exp = 0;
    rx_exp_t       rx_q[$];
    logic [DW-1:0] tx_q[$];
    int            valid_cycles[$];
    logic [DW-1:0] last_rx = '0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got 0x%0h, required no such event (cycle %0d)", name, act, cycle);
    endtask

    // Line level during cycle i of a frame carrying d: start, data LSB first, [parity], stop.
    function automatic logic frame_bit(input logic [DW-1:0] d, input logic par, input int i);
        int b;
        b = i / BC;
        if (b == 0) return 1'b0;
        if (b <= DW) return d[b-1];
        if (PB == 1 && b == DW + 1) return par;
        return 1'b1;
    endfunction

    // RX scoreboard
    initial begin : rx_mon
        rx_exp_t e;
        forever begin
            @(negedge clk);
            if (rx_valid) begin
                valid_cycles.push_back(cycle);
                if (rx_q.size() == 0) flag("rx_unexpected_valid", rx_data);
                else begin
                    e = rx_q.pop_front();
                    check("rx_data", rx_data, e.data);
                    check("rx_parity_err", rx_parity_err, e.perr);
                    last_rx = e.data;
                    $display("rx word 0x%0h parity_err=%0b at cycle %0d", rx_data, rx_parity_err, cycle);
                end
            end else if (rx_parity_err) flag("rx_parity_err_without_valid", rx_parity_err);
            if (rx_frame_err) begin
                if (ferr_exp == 0) flag("rx_unexpected_frame_err", rx_frame_err);
                else begin
                    ferr_exp--;
                    check("rx_frame_err_no_valid", rx_valid, 0);
                    check("rx_data_held", rx_data, last_rx);
                    $display("rx frame error at cycle %0d", cycle);
                end
            end
        end
    end

    // TX line monitor
    initial begin : tx_mon
        logic [DW-1:0] d;
        bit pending;
        bit aborted;
        pending = 0;
        forever begin
            if (!pending) @(negedge clk);
            pending = 0;
            if (reset_n && tx_valid && tx_ready) begin
                if (tx_q.size() == 0) begin
                    flag("tx_unexpected_accept", tx_data);
                    d = tx_data;
                end else d = tx_q.pop_front();
                aborted = 0;
                for (int i = 0; i < FRAME; i++) begin
                    @(negedge clk);
                    if (!reset_n) begin aborted = 1; break; end
                    check("tx_a2f_bit", a2f, frame_bit(d, ^d, i));
                    check("tx_ready_busy", tx_ready, 0);
                end
                if (!aborted) begin
                    @(negedge clk);
                    if (reset_n) check("tx_ready_return", tx_ready, 1);
                    $display("tx word 0x%0h frame of %0d cycles done at cycle %0d", d, FRAME, cycle);
                    pending = 1;
                end
            end else if (reset_n && tx_ready) begin
                check("a2f_idle", a2f, 1);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic send_tx(input logic [DW-1:0] d, input bit expect_rx);
        int n;
        @(posedge clk); #1;
        tx_data = d;
        tx_valid = 1'b1;
        tx_q.push_back(d);
        if (expect_rx) rx_q.push_back('{data: d, perr: 1'b0});
        n = 0;
        forever begin
            @(negedge clk);
            if (tx_ready) break;
            n++;
            if (n > 4 * FRAME) begin
                flag("tx_accept_timeout", n);
                break;
            end
        end
        // Inputs churn during the frame and must be ignored.
        @(posedge clk); #1;
        tx_data = DW'($urandom);
        tx_valid = 1'($urandom);
        repeat (FRAME - 2) begin
            @(posedge clk); #1;
            tx_data = DW'($urandom);
            tx_valid = 1'($urandom);
        end
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic drive_f2a(input logic [DW-1:0] d, input logic stop, input logic par);
        if (stop) rx_q.push_back('{data: d, perr: (PB == 1) ? (par ^ (^d)) : 1'b0});
        else ferr_exp++;
        for (int b = 0; b < NBITS; b++) begin
            @(posedge clk); #1;
            if (b == 0) f2a_drv = 1'b0;
            else if (b <= DW) f2a_drv = d[b-1];
            else if (PB == 1 && b == DW + 1) f2a_drv = par;
            else f2a_drv = stop;
            repeat (BC - 1) @(posedge clk);
        end
    endtask

    initial begin : stim
        logic [DW-1:0] d;
        logic stop, par;
        int base;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_a2f", a2f, 1);
        check("reset_tx_ready", tx_ready, 0);
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_frame_err", rx_frame_err, 0);
        check("reset_rx_parity_err", rx_parity_err, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("tx_ready_after_first_release", tx_ready, 1);

        // Loopback of 0xA5, then random loopback words
        loopback = 1'b1;
        send_tx(8'hA5, 1);
        for (int k = 0; k < 8; k++) send_tx(DW'($urandom), 1);
        repeat (8) @(posedge clk);
        loopback = 1'b0;

        // Single-cycle glitch must not start a frame
        @(posedge clk); #1 f2a_drv = 1'b0;
        @(posedge clk); #1 f2a_drv = 1'b1;
        repeat (10) @(posedge clk);
        drive_f2a(8'h5A, 1'b1, ^8'h5A);
        repeat (4) @(posedge clk);

        // Bad stop bit, line held low, then released
        drive_f2a(8'h3C, 1'b0, ^8'h3C);
        repeat (20) @(posedge clk);
        #1 f2a_drv = 1'b1;
        repeat (8) @(posedge clk);
        drive_f2a(8'h81, 1'b1, ^8'h81);
        repeat (4) @(posedge clk);

        // Back-to-back frames with no idle gap
        base = valid_cycles.size();
        drive_f2a(8'h11, 1'b1, ^8'h11);
        drive_f2a(8'h22, 1'b1, ^8'h22);
        repeat (6) @(posedge clk);
        check("b2b_pulse_count", valid_cycles.size() - base, 2);
        if (valid_cycles.size() - base == 2)
            check("b2b_pulse_spacing", valid_cycles[base+1] - valid_cycles[base], FRAME);

`ifdef RS_PREIO_LINK_PARITY_EN
        drive_f2a(8'h07, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        send_tx(8'h07, 0);
`endif

        // Random F2A frames with occasional bad stop / bad parity and random gaps
        for (int k = 0; k < 12; k++) begin
            d = DW'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            par = ($urandom_range(0, 3) == 0) ? ~(^d) : ^d;
            drive_f2a(d, stop, par);
            if (!stop) begin
                repeat ($urandom_range(0, 12)) @(posedge clk);
                #1 f2a_drv = 1'b1;
                repeat (2) @(posedge clk);
            end else begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
        end
        repeat (6) @(posedge clk);

        // TX and RX active at the same time
        for (int k = 0; k < 3; k++) begin
            d = DW'($urandom);
            fork
                send_tx(DW'($urandom), 0);
                drive_f2a(d, 1'b1, ^d);
            join
            repeat (6) @(posedge clk);
        end

        // Reset during data bits of TX 0xFF and of an RX frame
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("tx_ready_before_reset_test", tx_ready, 1);
        @(posedge clk); #1;
        tx_data = 8'hFF;
        tx_valid = 1'b1;
        tx_q.push_back(8'hFF);
        f2a_drv = 1'b0;
        @(posedge clk); #1 tx_valid = 1'b0;
        repeat (BC - 1) @(posedge clk);
        #1 f2a_drv = 1'b1;
        repeat (BC) @(posedge clk);
        #1 f2a_drv = 1'b0;
        repeat (BC) @(posedge clk);
        #1;
        reset_n = 1'b0;
        f2a_drv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midframe_reset_a2f", a2f, 1);
        check("midframe_reset_tx_ready", tx_ready, 0);
        check("midframe_reset_rx_data", rx_data, 0);
        last_rx = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("tx_ready_after_midframe_reset", tx_ready, 1);
        repeat (2 * FRAME) @(posedge clk);

        loopback = 1'b1;
        send_tx(8'h3C, 1);
        repeat (2 * FRAME) @(posedge clk);

        check("rx_queue_drained", rx_q.size(), 0);
        check("frame_err_expect_drained", ferr_exp, 0);
        check("tx_queue_drained", tx_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rs_preio_soc_link.md
RS_PREIO_SOC_LINK -- requirements
Module: rs_preio_soc_link

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the payload bits per frame; legal range 1..16.
REQ-003 Parameter BIT_CYCLES, default 4, SHALL set the clocks per serial bit; legal values are even and 2..64.
REQ-004 Port clk, input, 1, SHALL be the sole clock; all state samples on its rising edge.
REQ-005 Port reset_n, input, 1, SHALL be the synchronous active-low reset.
REQ-006 Port tx_data, input, DATA_WIDTH, SHALL carry the word to send to the fabric.
REQ-007 Port tx_valid, input, 1, SHALL indicate that tx_data is valid.
REQ-008 Port tx_ready, output, 1, SHALL indicate that the transmitter accepts a word this cycle.
REQ-009 Port gfpga_pad_RS_PREIO_A2F, output, 1, SHALL be the serial line toward the fabric (SoC-to-fabric).
REQ-010 Port gfpga_pad_RS_PREIO_F2A, input, 1, SHALL be the serial line from the fabric, synchronous to clk.
REQ-011 Port rx_data, output, DATA_WIDTH, SHALL hold the last received word.
REQ-012 Port rx_valid, output, 1, SHALL be a one-cycle pulse when rx_data is updated.
REQ-013 Port rx_frame_err, output, 1, SHALL be a one-cycle pulse on a bad stop bit.
REQ-014 Port rx_parity_err, output, 1, SHALL be a one-cycle pulse on a parity mismatch.

Function
REQ-015 The frame SHALL be: idle=1, start=0, DATA_WIDTH data bits LSB first, optional parity bit, stop=1; each bit lasts BIT_CYCLES clocks.
REQ-016 The TX FSM SHALL have the states IDLE, START, DATA, PARITY, STOP; tx_ready SHALL be 1 only in IDLE.
REQ-017 On tx_valid&&tx_ready, TX SHALL capture tx_data, and A2F SHALL go 0 on the next cycle.
REQ-018 TX SHALL hold the full frame for exactly (2+DATA_WIDTH[+1])*BIT_CYCLES cycles, then return to IDLE with tx_ready=1 on the following cycle.
REQ-019 tx_data/tx_valid changes during a frame SHALL be ignored; A2F SHALL be 1 in IDLE.
REQ-020 The RX FSM SHALL have the states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-021 In IDLE, F2A=0 SHALL move RX to START with a counter of 0.
REQ-022 RX SHALL re-sample F2A BIT_CYCLES/2 cycles after detection; if the sample is 1, RX SHALL treat it as a false start and return to IDLE with no pulse.
REQ-023 RX SHALL sample each later bit at bit centre, BIT_CYCLES cycles apart, and shift it into the data register LSB first.
REQ-024 If the stop sample is 1, RX SHALL update rx_data and pulse rx_valid on the cycle after the sample, then go to IDLE.
REQ-025 If the stop sample is 0, RX SHALL pulse rx_frame_err with no rx_valid and rx_data unchanged, and go to WAIT_IDLE.
REQ-026 RX SHALL leave WAIT_IDLE only when F2A=1.
REQ-027 RX has no backpressure; back-to-back frames SHALL each produce their own pulse.
REQ-028 A start bit immediately after a stop-bit sample SHALL be detected.
REQ-029 TX and RX SHALL be fully independent; simultaneous activity SHALL not interact.

Reset
REQ-030 When reset_n=0 at a clock edge, both FSMs SHALL go to IDLE and all counters SHALL clear.
REQ-031 During reset, outputs SHALL be: A2F=1, tx_ready=0, rx_data=0, rx_valid=0, rx_frame_err=0, rx_parity_err=0.
REQ-032 tx_ready SHALL rise on the first cycle after reset_n=1.
REQ-033 Reset mid-frame SHALL abort the frame immediately with no pulses, and A2F SHALL be 1 on the next cycle.

Configuration
REQ-034 With macro RS_PREIO_LINK_PARITY_EN defined, TX SHALL insert an even-parity bit (XOR of the data bits) after the data bits, and RX SHALL check it.
REQ-035 With RS_PREIO_LINK_PARITY_EN defined, a parity mismatch SHALL pulse rx_parity_err alongside rx_valid, and the data SHALL still be delivered.
REQ-036 Without the macro, the PARITY states SHALL be absent, frames SHALL carry no parity bit, and rx_parity_err SHALL be tied to 0.

Verification (DATA_WIDTH=8, BIT_CYCLES=4)
REQ-037 Loopback without parity, send 0xA5 -> A2F low 4 cycles, then bits 1,0,1,0,0,1,0,1, stop; rx_valid once with rx_data=0xA5; tx_ready returns 40 cycles after acceptance.
REQ-038 F2A glitch 0 for 1 cycle then 1 -> no pulses; RX returns to IDLE.
REQ-039 F2A frame 0x3C with stop=0, then held 0 for 20 cycles, then 1 -> one rx_frame_err, no rx_valid, no restart until F2A=1.
REQ-040 Parity build, send 0x07 with the parity bit forced to 0 on F2A -> rx_valid with 0x07 plus rx_parity_err in the same cycle; the TX frame shows parity=1 and is 44 cycles long.
REQ-041 reset_n=0 during the data bits of TX 0xFF and an RX frame -> A2F=1 the next cycle, no pulses, tx_ready=1 the first cycle after release.
REQ-042 Two back-to-back frames 0x11, 0x22 on F2A with no idle gap -> two rx_valid pulses 40 cycles apart with the correct data.
